// File: rtl/vending_pkg.sv
// Shared types and price/denomination tables for the stocked vending controller.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CHANGE  = 3'd2,
    REFUND  = 3'd3,
    GIVE    = 3'd4
  } state_e;

  localparam int unsigned TABLE_N = 8;

  localparam logic [15:0] PRODUCT_PRICES [TABLE_N] = '{
    16'd50, 16'd75, 16'd100, 16'd125, 16'd150, 16'd200, 16'd250, 16'd300
  };

  localparam logic [15:0] CURRENCY_VALUES [TABLE_N] = '{
    16'd1, 16'd2, 16'd5, 16'd10, 16'd25, 16'd50, 16'd100, 16'd200
  };

  // Slots or denominations beyond the tables are worth nothing.
  function automatic logic [15:0] price_of(input int unsigned idx);
    logic [15:0] p;
    if (idx < TABLE_N) p = PRODUCT_PRICES[idx[2:0]];
    else               p = 16'd0;
    return p;
  endfunction

  function automatic logic [15:0] value_of(input int unsigned idx);
    logic [15:0] v;
    if (idx < TABLE_N) v = CURRENCY_VALUES[idx[2:0]];
    else               v = 16'd0;
    return v;
  endfunction

endpackage

// File: rtl/vending_change_picker.sv
// Greedy coin selector: highest denomination still held that fits the remaining amount.
module vending_change_picker
  import vending_pkg::*;
#(
  parameter  int CURRENCIES = 8,
  parameter  int CREDIT_W   = 16,
  parameter  int COIN_W     = 6,
  localparam int CW         = $clog2(CURRENCIES)
)(
  input  logic [CREDIT_W-1:0]                remaining,
  input  logic [CURRENCIES-1:0][COIN_W-1:0]  coins,
  output logic                               valid,
  output logic [CW-1:0]                      code
);

  logic hit_s;

  // Ascending scan so the last fitting denomination wins
  always_comb begin
    valid = 1'b0;
    code  = '0;
    hit_s = 1'b0;
    for (int j = 0; j < CURRENCIES; j++) begin
      hit_s = (coins[j] != '0) && (CREDIT_W'(value_of(j)) <= remaining);
      valid = valid | hit_s;
      code  = hit_s ? CW'(j) : code;
    end
  end

endmodule

// File: rtl/vending_machine_stock.sv
// Vending controller with per-slot stock, coin inventory, greedy change, cancel and timeout.
// Optional restock port group is enabled by defining VENDING_RESTOCK_EN.
module vending_machine_stock
  import vending_pkg::*;
#(
  parameter  int PRODUCTS       = 8,
  parameter  int CURRENCIES     = 8,
  parameter  int CREDIT_W       = 16,
  parameter  int STOCK_W        = 4,
  parameter  int COIN_W         = 6,
  parameter  int INIT_STOCK     = 2,
  parameter  int INIT_COINS     = 4,
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int PW             = $clog2(PRODUCTS),
  localparam int CW             = $clog2(CURRENCIES)
)(
  input  logic                clk,
  input  logic                i_rst,
  input  logic [PW-1:0]       i_product_code,
  input  logic                i_product_strobe,
  input  logic [CW-1:0]       i_currency_code,
  input  logic                i_currency_strobe,
  input  logic                i_cancel,
`ifdef VENDING_RESTOCK_EN
  input  logic                i_restock_strobe,
  input  logic [PW-1:0]       i_restock_product,
  input  logic [STOCK_W-1:0]  i_restock_qty,
`endif
  output logic                o_busy,
  output logic                o_ready_to_receive,
  output logic [CW-1:0]       o_change,
  output logic                o_change_strobe,
  output logic                o_no_change,
  output logic [PW-1:0]       o_product,
  output logic                o_give_strobe,
  output logic                o_sold_out,
  output logic [CREDIT_W-1:0] o_credit
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e                              state_r;
  logic [PW-1:0]                       prod_r;
  logic [CREDIT_W-1:0]                 price_r;
  logic [CREDIT_W-1:0]                 remaining_r;
  logic [TW-1:0]                       timer_r;
  logic [PRODUCTS-1:0][STOCK_W-1:0]    stock_r;
  logic [CURRENCIES-1:0][COIN_W-1:0]   coins_r;

  logic [CREDIT_W-1:0] coin_val_s, credit_sum_s, eff_credit_s, pick_val_s, rem_after_s;
  logic [CREDIT_W:0]   sum_wide_s;
  logic                coin_s, timeout_s, quit_s, req_ok_s, pick_valid_s, pay_done_s, restock_s;
  logic [CW-1:0]       pick_code_s;

  vending_change_picker #(
    .CURRENCIES (CURRENCIES),
    .CREDIT_W   (CREDIT_W),
    .COIN_W     (COIN_W)
  ) u_picker (
    .remaining (remaining_r),
    .coins     (coins_r),
    .valid     (pick_valid_s),
    .code      (pick_code_s)
  );

  // Credit update (saturating) and transition qualifiers for the FSM
  always_comb begin
    coin_val_s = CREDIT_W'(value_of(32'(i_currency_code)));
    sum_wide_s = {1'b0, o_credit} + {1'b0, coin_val_s};
    if (sum_wide_s[CREDIT_W]) credit_sum_s = '1;
    else                      credit_sum_s = sum_wide_s[CREDIT_W-1:0];
    coin_s = i_currency_strobe && o_ready_to_receive && (int'(i_currency_code) < CURRENCIES);
    if (coin_s) eff_credit_s = credit_sum_s;
    else        eff_credit_s = o_credit;
    timeout_s   = !coin_s && (timer_r == TW'(TIMEOUT_CYCLES - 1));
    quit_s      = i_cancel || timeout_s;
    req_ok_s    = (int'(i_product_code) < PRODUCTS) && (stock_r[i_product_code] != '0);
    pick_val_s  = CREDIT_W'(value_of(32'(pick_code_s)));
    rem_after_s = remaining_r - pick_val_s;
    pay_done_s  = (remaining_r == '0) || !pick_valid_s || (rem_after_s == '0);
  end

`ifdef VENDING_RESTOCK_EN
  logic [STOCK_W:0]   restock_sum_s;
  logic [STOCK_W-1:0] restock_val_s;

  // Saturating restock amount, only meaningful while idle
  always_comb begin
    restock_s     = i_restock_strobe && (state_r == IDLE) && (int'(i_restock_product) < PRODUCTS);
    restock_sum_s = {1'b0, stock_r[i_restock_product]} + {1'b0, i_restock_qty};
    if (restock_sum_s[STOCK_W]) restock_val_s = '1;
    else                        restock_val_s = restock_sum_s[STOCK_W-1:0];
  end
`else
  assign restock_s = 1'b0;
`endif

  // Transaction FSM with inventories and registered outputs
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r            <= IDLE;
      prod_r             <= '0;
      price_r            <= '0;
      remaining_r        <= '0;
      timer_r            <= '0;
      for (int i = 0; i < PRODUCTS; i++)   stock_r[i] <= STOCK_W'(INIT_STOCK);
      for (int j = 0; j < CURRENCIES; j++) coins_r[j] <= COIN_W'(INIT_COINS);
      o_busy             <= 1'b0;
      o_ready_to_receive <= 1'b0;
      o_change           <= '0;
      o_change_strobe    <= 1'b0;
      o_no_change        <= 1'b0;
      o_product          <= '0;
      o_give_strobe      <= 1'b0;
      o_sold_out         <= 1'b0;
      o_credit           <= '0;
    end else begin
      o_change_strobe <= 1'b0;
      o_no_change     <= 1'b0;
      o_give_strobe   <= 1'b0;
      o_sold_out      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_product_strobe && req_ok_s) begin
            prod_r             <= i_product_code;
            price_r            <= CREDIT_W'(price_of(32'(i_product_code)));
            timer_r            <= '0;
            state_r            <= COLLECT;
            o_busy             <= 1'b1;
            o_ready_to_receive <= 1'b1;
          end else if (i_product_strobe) begin
            o_sold_out <= !restock_s;
          end
`ifdef VENDING_RESTOCK_EN
          if (restock_s) stock_r[i_restock_product] <= restock_val_s;
`endif
        end
        COLLECT: begin
          if (coin_s) begin
            o_credit <= credit_sum_s;
            if (coins_r[i_currency_code] != '1)
              coins_r[i_currency_code] <= coins_r[i_currency_code] + COIN_W'(1);
            timer_r <= '0;
          end else if (!timeout_s) begin
            timer_r <= timer_r + TW'(1);
          end
          // Cancel/timeout wins over a completing coin; that coin is refunded too
          if (quit_s) begin
            o_ready_to_receive <= 1'b0;
            if (eff_credit_s == '0) begin
              state_r <= IDLE;
              o_busy  <= 1'b0;
            end else begin
              state_r     <= REFUND;
              remaining_r <= eff_credit_s;
            end
          end else if (eff_credit_s >= price_r) begin
            o_ready_to_receive <= 1'b0;
            if (eff_credit_s == price_r) begin
              state_r <= GIVE;
            end else begin
              state_r     <= CHANGE;
              remaining_r <= eff_credit_s - price_r;
            end
          end
        end
        CHANGE, REFUND: begin
          if ((remaining_r != '0) && pick_valid_s) begin
            o_change_strobe      <= 1'b1;
            o_change             <= pick_code_s;
            coins_r[pick_code_s] <= coins_r[pick_code_s] - COIN_W'(1);
            remaining_r          <= rem_after_s;
          end else if (remaining_r != '0) begin
            o_no_change <= 1'b1;
            remaining_r <= '0;
          end
          if (pay_done_s) begin
            if (state_r == CHANGE) begin
              state_r <= GIVE;
            end else begin
              state_r  <= IDLE;
              o_busy   <= 1'b0;
              o_credit <= '0;
            end
          end
        end
        GIVE: begin
          o_give_strobe   <= 1'b1;
          o_product       <= prod_r;
          stock_r[prod_r] <= stock_r[prod_r] - STOCK_W'(1);
          o_credit        <= '0;
          state_r         <= IDLE;
          o_busy          <= 1'b0;
        end
        default: begin
          state_r            <= IDLE;
          o_busy             <= 1'b0;
          o_ready_to_receive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_stock.sv
// Directed bench: a small inventory model pushes expected strobes to a queue; the monitor pops and compares.
module tb_vending_machine_stock;

  localparam int TIMEOUT   = 1000;
  localparam int EV_CHG    = 256;
  localparam int EV_NOCHG  = 512;
  localparam int EV_GIVE   = 768;
  localparam int EV_SOLD   = 1024;
  localparam int EV_NONE   = -1;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [2:0]  i_product_code;
  logic        i_product_strobe;
  logic [2:0]  i_currency_code;
  logic        i_currency_strobe;
  logic        i_cancel;
  logic        o_busy, o_ready_to_receive, o_change_strobe, o_no_change, o_give_strobe, o_sold_out;
  logic [2:0]  o_change, o_product;
  logic [15:0] o_credit;

  always #5 clk = ~clk;

  vending_machine_stock #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk                (clk),
    .i_rst              (i_rst),
    .i_product_code     (i_product_code),
    .i_product_strobe   (i_product_strobe),
    .i_currency_code    (i_currency_code),
    .i_currency_strobe  (i_currency_strobe),
    .i_cancel           (i_cancel),
`ifdef VENDING_RESTOCK_EN
    .i_restock_strobe   (1'b0),
    .i_restock_product  (3'd0),
    .i_restock_qty      (4'd0),
`endif
    .o_busy             (o_busy),
    .o_ready_to_receive (o_ready_to_receive),
    .o_change           (o_change),
    .o_change_strobe    (o_change_strobe),
    .o_no_change        (o_no_change),
    .o_product          (o_product),
    .o_give_strobe      (o_give_strobe),
    .o_sold_out         (o_sold_out),
    .o_credit           (o_credit)
  );

  int tests = 0;
  int failed = 0;
  int exp_q[$];
  int val_t[8]   = '{1, 2, 5, 10, 25, 50, 100, 200};
  int price_t[8] = '{50, 75, 100, 125, 150, 200, 250, 300};
  int coins_m[8];
  int stock_m[8];
  int credit_m, price_m, prod_m;
  int nochg_seen = 0;
  int n;
  int nochg_before;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_ev(input int obs, input string tag);
    int exp;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else                  exp = EV_NONE;
    check(obs, exp, tag);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (o_change_strobe) check_ev(EV_CHG + int'(o_change), "change");
    if (o_no_change) begin
      nochg_seen++;
      check_ev(EV_NOCHG, "no_change");
    end
    if (o_give_strobe) check_ev(EV_GIVE + int'(o_product), "give");
    if (o_sold_out)    check_ev(EV_SOLD, "sold_out");
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      coins_m[k] = 4;
      stock_m[k] = 2;
    end
    credit_m = 0;
    exp_q.delete();
  endtask

  task automatic model_payout(input int amount);
    int r;
    int pick;
    r = amount;
    while (r > 0) begin
      pick = -1;
      for (int j = 7; j >= 0; j--)
        if (pick < 0 && coins_m[j] > 0 && val_t[j] <= r) pick = j;
      if (pick < 0) begin
        exp_q.push_back(EV_NOCHG);
        r = 0;
      end else begin
        exp_q.push_back(EV_CHG + pick);
        coins_m[pick]--;
        r -= val_t[pick];
      end
    end
  endtask

  task automatic request(input int p);
    if (stock_m[p] > 0) begin
      prod_m   = p;
      price_m  = price_t[p];
      credit_m = 0;
    end else begin
      exp_q.push_back(EV_SOLD);
    end
    i_product_code   = 3'(p);
    i_product_strobe = 1'b1;
    cycle();
    i_product_strobe = 1'b0;
  endtask

  task automatic insert(input int c);
    credit_m += val_t[c];
    coins_m[c]++;
    if (credit_m >= price_m) begin
      model_payout(credit_m - price_m);
      exp_q.push_back(EV_GIVE + prod_m);
      stock_m[prod_m]--;
      credit_m = 0;
    end
    i_currency_code   = 3'(c);
    i_currency_strobe = 1'b1;
    cycle();
    i_currency_strobe = 1'b0;
  endtask

  task automatic cancel();
    model_payout(credit_m);
    credit_m = 0;
    i_cancel = 1'b1;
    cycle();
    i_cancel = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag, output int cnt);
    cnt = 0;
    while ((o_busy !== 1'b0 || exp_q.size() != 0) && cnt < budget) begin
      cycle();
      cnt++;
    end
    check({31'b0, o_busy}, 32'd0, {tag, "_idle"});
    check(exp_q.size(), 32'd0, {tag, "_events"});
    exp_q.delete();
  endtask

  initial begin
    i_rst = 1'b1;
    i_product_code = 3'd0;
    i_product_strobe = 1'b0;
    i_currency_code = 3'd0;
    i_currency_strobe = 1'b0;
    i_cancel = 1'b0;
    model_reset();
    cycle();
    cycle();
    check({31'b0, o_busy}, 32'd0, "rst_busy");
    check({31'b0, o_ready_to_receive}, 32'd0, "rst_ready");
    check(32'(o_credit), 32'd0, "rst_credit");
    check({28'b0, o_change_strobe, o_no_change, o_give_strobe, o_sold_out}, 32'd0, "rst_strobes");
    check({26'b0, o_change, o_product}, 32'd0, "rst_codes");
    i_rst = 1'b0;
    cycle();

    // exact payment
    request(0);
    check({31'b0, o_busy}, 32'd1, "req_busy");
    check({31'b0, o_ready_to_receive}, 32'd1, "req_ready");
    insert(5);
    wait_idle(20, "exact", n);

    // overpay, one 25 back
    request(1);
    insert(6);
    wait_idle(20, "change25", n);

    // empty slot 2, then a rejected request
    request(2);
    insert(6);
    wait_idle(20, "p2a", n);
    request(2);
    insert(6);
    wait_idle(20, "p2b", n);
    request(2);
    check({31'b0, o_busy}, 32'd0, "sold_busy");
    wait_idle(5, "sold", n);

    // cancel with partial credit
    request(3);
    insert(4);
    insert(3);
    check(32'(o_credit), 32'd35, "credit35");
    cancel();
    wait_idle(20, "cancel", n);
    check(32'(o_credit), 32'd0, "credit_refund");

    // inactivity timeout with and without credit
    request(0);
    insert(4);
    model_payout(credit_m);
    credit_m = 0;
    wait_idle(TIMEOUT + 50, "timeout", n);
    check({31'b0, (n >= TIMEOUT - 1) && (n <= TIMEOUT + 2)}, 32'd1, "timeout_latency");
    request(0);
    wait_idle(TIMEOUT + 50, "timeout0", n);
    check({31'b0, (n >= TIMEOUT - 1) && (n <= TIMEOUT + 2)}, 32'd1, "timeout0_latency");

    // drain small denominations through change-giving purchases
    request(3); insert(7); wait_idle(20, "d1", n);
    request(3); insert(7); wait_idle(20, "d2", n);
    request(4); insert(7); wait_idle(20, "d3", n);
    request(4); insert(7); wait_idle(20, "d4", n);
    request(6); insert(7); insert(6); wait_idle(20, "d5", n);
    request(1); insert(7); wait_idle(20, "d6", n);
    request(6); insert(7); insert(6); wait_idle(30, "d7", n);

    // 50 change cannot be fully paid: partial coins, no_change, still dispensed
    nochg_before = nochg_seen;
    request(0);
    insert(6);
    wait_idle(40, "nochange", n);
    check(nochg_seen - nochg_before, 32'd1, "no_change_seen");

    // reset in the middle of collecting
    request(5);
    insert(3);
    check(32'(o_credit), 32'd10, "credit10");
    i_rst = 1'b1;
    cycle();
    check({31'b0, o_busy}, 32'd0, "midrst_busy");
    check({31'b0, o_ready_to_receive}, 32'd0, "midrst_ready");
    check(32'(o_credit), 32'd0, "midrst_credit");
    check({28'b0, o_change_strobe, o_no_change, o_give_strobe, o_sold_out}, 32'd0, "midrst_strobes");
    i_rst = 1'b0;
    model_reset();
    cycle();
    request(2);
    check({31'b0, o_busy}, 32'd1, "restored_stock");
    cancel();
    wait_idle(10, "cancel0", n);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vending_machine_stock.md
Name: vending_machine_stock

Overview:
Parametrised successor to the single-transaction vending FSM. It adds per-product stock counters and a per-denomination coin inventory, so change is dispensed greedily from the coins actually held. It also adds user cancel/refund and an inactivity timeout. It sits between the coin acceptor/keypad front-end and the dispenser/change-hopper drivers.

Parameters:
PRODUCTS, 8, number of product slots; product code width $clog2(PRODUCTS)
CURRENCIES, 8, number of denominations; currency code width $clog2(CURRENCIES)
CREDIT_W, 16, width of credit/change accumulators (kop)
STOCK_W, 4, width of each per-product stock counter
COIN_W, 6, width of each per-denomination coin counter (saturating)
INIT_STOCK, 2, stock loaded into every slot at reset
INIT_COINS, 4, coins loaded into every denomination at reset
TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before auto-refund

Ports:
clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_product_code  in  $clog2(PRODUCTS)  requested product
i_product_strobe  in  1  1-cycle request pulse
i_currency_code  in  $clog2(CURRENCIES)  inserted coin
i_currency_strobe  in  1  1-cycle coin pulse, honoured only when o_ready_to_receive=1
i_cancel  in  1  1-cycle cancel pulse
o_busy  out  1  high in any state except IDLE
o_ready_to_receive  out  1  high in COLLECT
o_change  out  $clog2(CURRENCIES)  denomination being returned
o_change_strobe  out  1  1-cycle, qualifies o_change
o_no_change  out  1  1-cycle, inventory cannot pay remaining amount
o_product  out  $clog2(PRODUCTS)  product being dispensed
o_give_strobe  out  1  1-cycle, qualifies o_product
o_sold_out  out  1  1-cycle, request rejected
o_credit  out  CREDIT_W  current credit, for display

Behaviour:
- Reset (i_rst sampled high):
  - state=IDLE; all outputs 0; credit=0.
  - Stock[i]=INIT_STOCK; coins[j]=INIT_COINS.
  - Reset mid-transaction discards credit without refund.
- Prices and values come from package tables PRODUCT_PRICES[] and CURRENCY_VALUES[].
- IDLE:
  - A product strobe with a valid code (< PRODUCTS) and stock>0 latches the code and price, then goes to COLLECT the next cycle (busy=1, ready=1 one cycle after the strobe).
  - Invalid code or stock=0: o_sold_out pulses for one cycle; stay in IDLE.
  - Coin and cancel inputs are ignored in IDLE.
- COLLECT:
  - Each accepted coin: credit += value; coins[code]++ (saturates at 2^COIN_W-1 and is still accepted); timeout counter cleared.
  - When credit (including the coin arriving this cycle) >= price: next state is GIVE if credit==price, else CHANGE with remaining = credit-price.
  - i_cancel: next state is REFUND with remaining = credit. A coin in the same cycle is accepted first and included in the refund.
  - Timeout counter reaching TIMEOUT_CYCLES-1: behaves as cancel. If credit==0, go straight to IDLE.
  - Product strobes are ignored while busy.
- CHANGE / REFUND, one coin per cycle:
  - Select the highest code j with coins[j]>0 and value[j] <= remaining.
  - Pulse o_change_strobe with o_change=j; coins[j]--; remaining -= value[j].
  - When remaining==0: CHANGE goes to GIVE; REFUND goes to IDLE.
  - If no eligible coin and remaining>0: pulse o_no_change, drop the remainder, then GIVE (from CHANGE) or IDLE (from REFUND).
- GIVE: o_give_strobe=1 with o_product for one cycle; stock[code]--; credit=0; next IDLE.
- o_credit tracks credit: cleared on GIVE or on REFUND exit.
- Arithmetic is unsigned CREDIT_W. Credit saturates at all-ones, so an overflowing coin cannot wrap.

Optional Feature:
VENDING_RESTOCK_EN
- Defined: adds ports i_restock_strobe (1), i_restock_product ($clog2(PRODUCTS)), i_restock_qty (STOCK_W).
  - Restock is honoured only in IDLE and saturates the stock counter.
  - o_sold_out is not asserted on the restock cycle.
  - A simultaneous product strobe sees the pre-restock stock value.
- Undefined: no ports are added; stock only decreases after reset.

Decomposition:
- Package vending_pkg holds:
  - state_e enum {IDLE, COLLECT, CHANGE, REFUND, GIVE}.
  - PRODUCT_PRICES = {50,75,100,125,150,200,250,300}.
  - CURRENCY_VALUES = {1,2,5,10,25,50,100,200}.
  - A price lookup function.
- One sub-module, vending_change_picker: combinational greedy selector. Inputs: remaining and the coin counts. Outputs: valid and code. It is instantiated once and shared by CHANGE and REFUND.

Test Plan:
- Product 0 (50), insert code 5 (50) -> o_give_strobe with o_product=0 one cycle later, no change strobe; stock[0]=1.
- Product 1 (75), insert code 6 (100) -> one change strobe with code 4 (25), then give; coins[6]=5, coins[4]=3.
- Product 2 bought twice, third request -> o_sold_out pulse, o_busy stays 0.
- Product 3 (125), insert 25+10 then i_cancel -> change codes 4 then 3, no give; o_credit returns to 0.
- Product 0, insert code 4 then wait TIMEOUT_CYCLES -> refund code 4, back to IDLE; a no-coin request times out directly to IDLE.
- Drain coins[0..4] via change transactions, then buy product 0 with 100 -> o_no_change pulse, give still occurs; assert i_rst mid-COLLECT -> all outputs 0 the next cycle.
